// File: rtl/yarp_decode_q_if.sv
// rtl/yarp_decode_q_if.sv - fetch/execute handshake bundle for the YARP decode queue
//
// Ports (slave = decode stage view):
//   in  : flush_i, in_valid_i, instr_i[31:0], pc_i[31:0], out_ready_i
//   out : in_ready_o, out_valid_o, pc_o[31:0], rs1_o/rs2_o/rd_o[4:0], op_o[6:0],
//         funct3_o[2:0], funct7_o[6:0], type_o[5:0], imm_o[XLEN-1:0],
//         illegal_o, illegal_cnt_o[15:0]
interface yarp_decode_q_if #(
    parameter int XLEN = 32
);
    logic            flush_i;
    logic            in_valid_i;
    logic            in_ready_o;
    logic [31:0]     instr_i;
    logic [31:0]     pc_i;
    logic            out_valid_o;
    logic            out_ready_i;
    logic [31:0]     pc_o;
    logic [4:0]      rs1_o;
    logic [4:0]      rs2_o;
    logic [4:0]      rd_o;
    logic [6:0]      op_o;
    logic [2:0]      funct3_o;
    logic [6:0]      funct7_o;
    logic [5:0]      type_o;
    logic [XLEN-1:0] imm_o;
    logic            illegal_o;
    logic [15:0]     illegal_cnt_o;

    modport slave (
        input  flush_i, in_valid_i, instr_i, pc_i, out_ready_i,
        output in_ready_o, out_valid_o, pc_o, rs1_o, rs2_o, rd_o, op_o,
               funct3_o, funct7_o, type_o, imm_o, illegal_o, illegal_cnt_o
    );

    modport master (
        output flush_i, in_valid_i, instr_i, pc_i, out_ready_i,
        input  in_ready_o, out_valid_o, pc_o, rs1_o, rs2_o, rd_o, op_o,
               funct3_o, funct7_o, type_o, imm_o, illegal_o, illegal_cnt_o
    );
endinterface

// File: rtl/yarp_decode_q.sv
// rtl/yarp_decode_q.sv - RV32I decode stage with DEPTH-entry output FIFO
//
// Ports:
//   clk      : clock, all state on rising edge
//   reset_n  : asynchronous active-low reset
//   bus      : yarp_decode_q_if.slave (fetch-side push, execute-side pop,
//              flush, decoded head fields, illegal flag and counter)
// The interface XLEN must match this module's XLEN.
module yarp_decode_q #(
    parameter int XLEN          = 32,
    parameter int DEPTH         = 2,
    parameter int CHECK_ILLEGAL = 1
) (
    input  logic          clk,
    input  logic          reset_n,
    yarp_decode_q_if.slave bus
);
    localparam int        PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW:0] FULL = (PW + 1)'(DEPTH);

    typedef struct packed {
        logic [31:0]     pc;
        logic [31:0]     instr;
        logic [5:0]      typ;
        logic [XLEN-1:0] imm;
        logic            illegal;
    } entry_t;

    // ---------------- combinational decode of the incoming word ----------------
    logic [31:0]     ins;
    logic [5:0]      dec_type;
    logic [31:0]     imm32;
    logic [XLEN-1:0] dec_imm;
    logic            dec_illegal;

    assign ins = bus.instr_i;

    // Every recognised opcode ends in 2'b11, so a word with instr[1:0] != 2'b11
    // always lands in the default arm and is flagged there.
    always_comb begin
        dec_type    = 6'b000000;
        imm32       = 32'h0;
        dec_illegal = 1'b0;
        case (ins[6:0])
            7'h33: dec_type = 6'b000001;
            7'h03, 7'h13, 7'h67: begin
                dec_type = 6'b000010;
                imm32    = {{20{ins[31]}}, ins[31:20]};
            end
            7'h23: begin
                dec_type = 6'b000100;
                imm32    = {{20{ins[31]}}, ins[31:25], ins[11:7]};
            end
            7'h63: begin
                dec_type = 6'b001000;
                imm32    = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
            end
            7'h37, 7'h17: begin
                dec_type = 6'b010000;
                imm32    = {ins[31:12], 12'h000};
            end
            7'h6F: begin
                dec_type = 6'b100000;
                imm32    = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
            end
            default: dec_illegal = (CHECK_ILLEGAL != 0);
        endcase
        // All formats fit in 32 bits sign-extended; widen to XLEN from bit 31.
        dec_imm       = {XLEN{imm32[31]}};
        dec_imm[31:0] = imm32;
    end

    // ---------------- FIFO control ----------------
    logic [PW:0]   count;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [15:0]   illegal_cnt;
    logic          in_ready;
    logic          out_valid;
    logic          push;
    logic          pop;

    // in_ready depends only on registered count, so a pop never frees a slot
    // combinationally in the same cycle.
    assign in_ready  = (count != FULL);
    assign out_valid = (count != '0);
    assign push      = bus.in_valid_i && in_ready && !bus.flush_i;
    assign pop       = out_valid && bus.out_ready_i && !bus.flush_i;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count       <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            illegal_cnt <= 16'h0000;
        end else begin
            if (bus.flush_i) begin
                count  <= '0;
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + 1'b1;
                if (pop)  rd_ptr <= rd_ptr + 1'b1;
                if (push && !pop)
                    count <= count + 1'b1;
                else if (!push && pop)
                    count <= count - 1'b1;
            end
            // push is already gated by flush, so flushed beats never count.
            if (push && dec_illegal && (illegal_cnt != 16'hFFFF))
                illegal_cnt <= illegal_cnt + 16'h0001;
        end
    end

    // ---------------- storage (unreset, masked on read while empty) ----------------
    entry_t mem [DEPTH];
    entry_t wr_entry;
    entry_t head;

    assign wr_entry = '{pc: bus.pc_i, instr: bus.instr_i, typ: dec_type,
                        imm: dec_imm, illegal: dec_illegal};

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wr_entry;
    end

    assign head = out_valid ? mem[rd_ptr] : '0;

    // ---------------- outputs ----------------
    assign bus.in_ready_o    = in_ready;
    assign bus.out_valid_o   = out_valid;
    assign bus.pc_o          = head.pc;
    assign bus.rs1_o         = head.instr[19:15];
    assign bus.rs2_o         = head.instr[24:20];
    assign bus.rd_o          = head.instr[11:7];
    assign bus.op_o          = head.instr[6:0];
    assign bus.funct3_o      = head.instr[14:12];
    assign bus.funct7_o      = head.instr[31:25];
    assign bus.type_o        = head.typ;
    assign bus.imm_o         = head.imm;
    assign bus.illegal_o     = head.illegal;
    assign bus.illegal_cnt_o = illegal_cnt;
endmodule

// File: tb/tb_yarp_decode_q.sv
// tb/tb_yarp_decode_q.sv - directed self-checking bench for yarp_decode_q
module tb_yarp_decode_q;
    logic clk;
    logic reset_n;
    int   errors = 0;
    int   checks = 0;

    yarp_decode_q_if #(.XLEN(32)) if0 ();
    yarp_decode_q_if #(.XLEN(64)) if64 ();
    yarp_decode_q_if #(.XLEN(32)) ifn ();

    // The 64-bit and no-check instances mirror the stimulus of the main one.
    assign if64.flush_i     = if0.flush_i;
    assign if64.in_valid_i  = if0.in_valid_i;
    assign if64.instr_i     = if0.instr_i;
    assign if64.pc_i        = if0.pc_i;
    assign if64.out_ready_i = if0.out_ready_i;
    assign ifn.flush_i      = if0.flush_i;
    assign ifn.in_valid_i   = if0.in_valid_i;
    assign ifn.instr_i      = if0.instr_i;
    assign ifn.pc_i         = if0.pc_i;
    assign ifn.out_ready_i  = if0.out_ready_i;

    yarp_decode_q #(.XLEN(32), .DEPTH(2), .CHECK_ILLEGAL(1)) u_dut (
        .clk(clk), .reset_n(reset_n), .bus(if0));
    yarp_decode_q #(.XLEN(64), .DEPTH(2), .CHECK_ILLEGAL(1)) u_dut64 (
        .clk(clk), .reset_n(reset_n), .bus(if64));
    yarp_decode_q #(.XLEN(32), .DEPTH(2), .CHECK_ILLEGAL(0)) u_dutn (
        .clk(clk), .reset_n(reset_n), .bus(ifn));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc);
        if0.in_valid_i = v;
        if0.instr_i    = ins;
        if0.pc_i       = pc;
    endtask

    task automatic head(input string tag, input logic [31:0] pc, input logic [5:0] typ,
                        input logic [63:0] imm, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                        input logic [6:0] op);
        chk({tag, ".valid"},  64'(if0.out_valid_o), 64'd1);
        chk({tag, ".pc"},     64'(if0.pc_o),        64'(pc));
        chk({tag, ".type"},   64'(if0.type_o),      64'(typ));
        chk({tag, ".imm"},    64'(if0.imm_o),       imm);
        chk({tag, ".rd"},     64'(if0.rd_o),        64'(rd));
        chk({tag, ".rs1"},    64'(if0.rs1_o),       64'(rs1));
        chk({tag, ".rs2"},    64'(if0.rs2_o),       64'(rs2));
        chk({tag, ".funct3"}, 64'(if0.funct3_o),    64'(f3));
        chk({tag, ".funct7"}, 64'(if0.funct7_o),    64'(f7));
        chk({tag, ".op"},     64'(if0.op_o),        64'(op));
        chk({tag, ".illegal"},64'(if0.illegal_o),   64'd0);
    endtask

    initial begin
        reset_n         = 1'b0;
        if0.flush_i     = 1'b0;
        if0.out_ready_i = 1'b0;
        drive(1'b0, 32'h0, 32'h0);
        step();
        step();
        chk("rst.out_valid", 64'(if0.out_valid_o), 64'd0);
        chk("rst.in_ready",  64'(if0.in_ready_o),  64'd1);
        chk("rst.pc",        64'(if0.pc_o),        64'd0);
        chk("rst.imm",       64'(if0.imm_o),       64'd0);
        chk("rst.type",      64'(if0.type_o),      64'd0);
        chk("rst.cnt",       64'(if0.illegal_cnt_o), 64'd0);
        reset_n = 1'b1;
        step();

        // single addi, then queue drains
        if0.out_ready_i = 1'b1;
        drive(1'b1, 32'h00500093, 32'h100);
        step();
        drive(1'b0, 32'h0, 32'h0);
        head("addi", 32'h100, 6'b000010, 64'd5, 5'd1, 5'd0, 5'd5, 3'd0, 7'h00, 7'h13);
        step();
        chk("addi.drain", 64'(if0.out_valid_o), 64'd0);

        // streaming decode, one beat per cycle
        drive(1'b1, 32'hFE000EE3, 32'h104);
        step();
        head("beq", 32'h104, 6'b001000, 64'hFFFFFFFC, 5'h1D, 5'd0, 5'd0, 3'd0, 7'h7F, 7'h63);
        chk("beq.imm64", 64'(if64.imm_o), 64'hFFFFFFFFFFFFFFFC);
        drive(1'b1, 32'h0020A423, 32'h108);
        step();
        head("sw", 32'h108, 6'b000100, 64'd8, 5'd8, 5'd1, 5'd2, 3'd2, 7'h00, 7'h23);
        drive(1'b1, 32'h010000EF, 32'h10C);
        step();
        head("jal", 32'h10C, 6'b100000, 64'h10, 5'd1, 5'd0, 5'd16, 3'd0, 7'h00, 7'h6F);
        drive(1'b1, 32'h402081B3, 32'h110);
        step();
        head("sub", 32'h110, 6'b000001, 64'd0, 5'd3, 5'd1, 5'd2, 3'd0, 7'h20, 7'h33);
        drive(1'b1, 32'h800000B7, 32'h114);
        step();
        head("lui", 32'h114, 6'b010000, 64'h80000000, 5'd1, 5'd0, 5'd0, 3'd0, 7'h40, 7'h37);
        chk("lui.imm64", 64'(if64.imm_o), 64'hFFFFFFFF80000000);
        drive(1'b1, 32'h00001117, 32'h118);
        step();
        head("auipc", 32'h118, 6'b010000, 64'h1000, 5'd2, 5'd0, 5'd0, 3'd1, 7'h00, 7'h17);
        drive(1'b0, 32'h0, 32'h0);
        step();
        chk("stream.drain", 64'(if0.out_valid_o), 64'd0);

        // backpressure: three beats into a 2-deep queue
        if0.out_ready_i = 1'b0;
        drive(1'b1, 32'h00100093, 32'h200);
        step();
        chk("bp.ready1", 64'(if0.in_ready_o), 64'd1);
        chk("bp.pc1",    64'(if0.pc_o),       64'h200);
        drive(1'b1, 32'h00200093, 32'h204);
        step();
        chk("bp.ready2", 64'(if0.in_ready_o), 64'd0);
        drive(1'b1, 32'h00300093, 32'h208);
        step();
        chk("bp.held",   64'(if0.in_ready_o), 64'd0);
        chk("bp.head",   64'(if0.pc_o),       64'h200);
        if0.out_ready_i = 1'b1;
        step();
        chk("bp.pop1",   64'(if0.pc_o),       64'h204);
        chk("bp.imm2",   64'(if0.imm_o),      64'd2);
        chk("bp.free",   64'(if0.in_ready_o), 64'd1);
        step();
        drive(1'b0, 32'h0, 32'h0);
        chk("bp.pop2",   64'(if0.pc_o),       64'h208);
        chk("bp.imm3",   64'(if0.imm_o),      64'd3);
        step();
        chk("bp.empty",  64'(if0.out_valid_o), 64'd0);

        // flush with full queue and with one entry, incoming illegal beat
        if0.out_ready_i = 1'b0;
        drive(1'b1, 32'h00500093, 32'h300);
        step();
        drive(1'b1, 32'h00500093, 32'h304);
        step();
        chk("fl.full", 64'(if0.in_ready_o), 64'd0);
        if0.flush_i = 1'b1;
        drive(1'b1, 32'h00000000, 32'h308);
        step();
        if0.flush_i = 1'b0;
        drive(1'b0, 32'h0, 32'h0);
        chk("fl.valid", 64'(if0.out_valid_o), 64'd0);
        chk("fl.ready", 64'(if0.in_ready_o),  64'd1);
        chk("fl.cnt",   64'(if0.illegal_cnt_o), 64'd0);
        drive(1'b1, 32'h00500093, 32'h30C);
        step();
        chk("fl.one", 64'(if0.pc_o), 64'h30C);
        if0.flush_i = 1'b1;
        drive(1'b1, 32'h00000000, 32'h310);
        step();
        if0.flush_i = 1'b0;
        drive(1'b0, 32'h0, 32'h0);
        chk("fl2.valid", 64'(if0.out_valid_o), 64'd0);
        chk("fl2.cnt",   64'(if0.illegal_cnt_o), 64'd0);
        step();
        chk("fl2.dropped", 64'(if0.out_valid_o), 64'd0);

        // illegal words
        if0.out_ready_i = 1'b1;
        drive(1'b1, 32'h00000000, 32'h400);
        step();
        chk("ill0.flag", 64'(if0.illegal_o),     64'd1);
        chk("ill0.type", 64'(if0.type_o),        64'd0);
        chk("ill0.imm",  64'(if0.imm_o),         64'd0);
        chk("ill0.pc",   64'(if0.pc_o),          64'h400);
        chk("ill0.cnt",  64'(if0.illegal_cnt_o), 64'd1);
        chk("ill0.nchk", 64'(ifn.illegal_o),     64'd0);
        drive(1'b1, 32'h0000007F, 32'h404);
        step();
        chk("ill1.flag", 64'(if0.illegal_o),     64'd1);
        chk("ill1.type", 64'(if0.type_o),        64'd0);
        chk("ill1.cnt",  64'(if0.illegal_cnt_o), 64'd2);
        chk("ill1.nval", 64'(ifn.out_valid_o),   64'd1);
        chk("ill1.nflag",64'(ifn.illegal_o),     64'd0);
        chk("ill1.ntype",64'(ifn.type_o),        64'd0);
        chk("ill1.ncnt", 64'(ifn.illegal_cnt_o), 64'd0);
        drive(1'b0, 32'h0, 32'h0);
        step();
        chk("ill.drain", 64'(if0.out_valid_o),   64'd0);
        chk("ill.hold",  64'(if0.illegal_cnt_o), 64'd2);

        // saturation: 2 + 65532 = 0xFFFE, then clamp at 0xFFFF
        drive(1'b1, 32'h00000000, 32'h500);
        for (int i = 0; i < 65532; i++) step();
        chk("sat.fffe", 64'(if0.illegal_cnt_o), 64'hFFFE);
        step();
        chk("sat.ffff", 64'(if0.illegal_cnt_o), 64'hFFFF);
        repeat (3) step();
        chk("sat.hold", 64'(if0.illegal_cnt_o), 64'hFFFF);
        chk("sat.64",   64'(if64.illegal_cnt_o), 64'hFFFF);
        chk("sat.nchk", 64'(ifn.illegal_cnt_o), 64'd0);
        drive(1'b0, 32'h0, 32'h0);
        step();

        // asynchronous reset with two entries queued
        if0.out_ready_i = 1'b0;
        drive(1'b1, 32'h00500093, 32'h600);
        step();
        drive(1'b1, 32'h00500093, 32'h604);
        step();
        drive(1'b0, 32'h0, 32'h0);
        chk("ar.pre", 64'(if0.out_valid_o), 64'd1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("ar.valid", 64'(if0.out_valid_o),   64'd0);
        chk("ar.ready", 64'(if0.in_ready_o),    64'd1);
        chk("ar.cnt",   64'(if0.illegal_cnt_o), 64'd0);
        chk("ar.pc",    64'(if0.pc_o),          64'd0);
        step();
        reset_n = 1'b1;
        step();
        chk("ar.after", 64'(if0.out_valid_o), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/yarp_decode_q.md
Name: yarp_decode_q

Overview:
Registered, parametrised instruction-decode stage for the YARP core.
- Decodes one RV32I instruction word per accepted beat: register indices, opcode, funct fields, one-hot type, immediate and illegal flag.
- Buffers decoded results in a DEPTH-entry FIFO with valid/ready handshakes on both sides.
- Sits between fetch and execute. Adds a flush for branch redirects and a saturating illegal-instruction counter.

Parameters:
XLEN, 32, immediate output width; legal values 32 or 64; immediates sign-extended to XLEN (U-type sign-extended from bit 31).
DEPTH, 2, FIFO entries; power of two, >= 2.
CHECK_ILLEGAL, 1, 1 = flag unknown opcodes or instr[1:0] != 2'b11 as illegal; 0 = illegal_o tied 0 and unknown opcodes decode as type 0.

Ports:
clk  input  1  clock, all state on rising edge
reset_n  input  1  asynchronous active-low reset
flush_i  input  1  drop all buffered and incoming entries
in_valid_i  input  1  instr_i/pc_i valid
in_ready_o  output  1  stage can accept
instr_i  input  32  instruction word
pc_i  input  32  instruction address, passed through
out_valid_o  output  1  head entry valid
out_ready_i  input  1  consumer accepts head
pc_o  output  32  head PC
rs1_o / rs2_o / rd_o  output  5 each  register indices instr[19:15]/[24:20]/[11:7]
op_o  output  7  instr[6:0]
funct3_o  output  3  instr[14:12]
funct7_o  output  7  instr[31:25]
type_o  output  6  one-hot {J,U,B,S,I,R}, bit0 = R
imm_o  output  XLEN  decoded immediate
illegal_o  output  1  head entry is illegal
illegal_cnt_o  output  16  saturating count of accepted illegal instructions

Behaviour:
- Opcode map:
  - R: 0x33
  - I: 0x03, 0x13, 0x67
  - S: 0x23
  - B: 0x63
  - U: 0x37, 0x17
  - J: 0x6F
  - Anything else: type 0, imm 0, illegal=1 when CHECK_ILLEGAL=1.
- Immediates:
  - I = sext(instr[31:20])
  - S = sext({instr[31:25], instr[11:7]})
  - B = sext({instr[31], instr[7], instr[30:25], instr[11:8], 0})
  - J = sext({instr[31], instr[19:12], instr[20], instr[30:21], 0})
  - U = sext({instr[31:12], 12'b0})
  - R = 0
- Decode is combinational on instr_i. The decoded result plus pc_i is written to the FIFO tail on a push.
- Push = in_valid_i && in_ready_o && !flush_i. Pop = out_valid_o && out_ready_i && !flush_i.
- in_ready_o = (count != DEPTH). No combinational path from out_ready_i to in_ready_o; when full, a pop frees the slot from the next cycle.
- out_valid_o = (count != 0). All out data comes from the head entry. When empty, all data outputs read 0.
- Latency: an instruction pushed at edge N is visible on outputs after edge N (min 1 cycle). Order is strictly FIFO.
- Simultaneous push and pop with 0 < count < DEPTH: count unchanged, both pointers advance.
- Pointers are log2(DEPTH) bits and wrap naturally. count is log2(DEPTH)+1 bits.
- flush_i has priority: at the edge, count=0 and pointers=0; any same-cycle push or pop is discarded. out_valid_o=0 next cycle. illegal_cnt_o is unaffected.
- illegal_cnt_o increments on each push with illegal=1 and saturates at 0xFFFF. Only reset clears it.
- Reset (async assert, sync-deassert by design above):
  - count, pointers and illegal_cnt_o cleared.
  - out_valid_o=0, in_ready_o=1, all data outputs 0.
  - Reset mid-stream drops all entries.
- FIFO storage needs no reset; outputs are masked while empty.

Test Plan:
- 0x00500093 (addi x1,x0,5), pc 0x100, out_ready=1 -> next cycle out_valid=1, type=6'b000010, rd=1, rs1=0, imm=5, pc_o=0x100; one cycle later out_valid=0.
- 0xFE000EE3 (beq x0,x0,-4) -> type=6'b001000, funct3=0, imm=0xFFFFFFFC. With XLEN=64: 0x800000B7 (lui x1,0x80000) -> type=6'b010000, imm=0xFFFFFFFF80000000.
- DEPTH=2, out_ready=0, three back-to-back valid beats -> in_ready low after the 2nd push; 3rd beat held; raise out_ready -> order 1,2,3 preserved, no loss or duplication.
- Fill with 2 entries, assert flush_i together with in_valid -> next cycle out_valid=0, in_ready=1, incoming beat dropped, illegal_cnt unchanged.
- Push 0x00000000 and 0x0000007F -> illegal_o=1, type=0, imm=0, illegal_cnt_o=2. With CHECK_ILLEGAL=0 -> illegal_o=0, count stays 0. Force count near 0xFFFF -> saturates at 0xFFFF.
- Assert reset_n=0 asynchronously with 2 entries queued -> out_valid_o, count and illegal_cnt_o go to 0 immediately without a clock edge.
